// File: rtl/vnlp_pkg.sv
// Shared types and sizes for the VNLP job controller.
package vnlp_pkg;
  localparam int VNLP_ADDR_W    = 9;
  localparam int VNLP_DATA_W    = 10;
  localparam int VNLP_RES_W     = 28;
  localparam int VNLP_LEN_W     = 8;
  localparam int VNLP_MEM_DEPTH = 512;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, ABORT, RESP} vnlp_state_e;
endpackage

// File: rtl/vnlp_watchdog.sv
// RUN-phase cycle counter; expired_o flags the TIMEOUT-th enabled cycle.
module vnlp_watchdog #(
  parameter int TIMEOUT = 4095
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                                   cnt_d = '0;
    else if (enable_i && cnt_q != CW'(TIMEOUT))    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires in the cycle whose increment reaches TIMEOUT.
  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/vnlp_job_ctrl.sv
// Host job sequencer: loads operands into Memory, starts VNLP, returns the result.
module vnlp_job_ctrl import vnlp_pkg::*; #(
  parameter int ADDR_W  = VNLP_ADDR_W,
  parameter int DATA_W  = VNLP_DATA_W,
  parameter int RES_W   = VNLP_RES_W,
  parameter int LEN_W   = VNLP_LEN_W,
  parameter int TIMEOUT = 4095
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              JobValid,
  output logic              JobReady,
  input  logic [ADDR_W:0]   JobWords,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  output logic              MemWriteEn,
  output logic [ADDR_W-1:0] MemWriteAdd,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              VStart,
  output logic              VReset,
  input  logic              VDone,
  input  logic [RES_W-1:0]  VResult,
  input  logic [LEN_W-1:0]  VLen,
  output logic              ResValid,
  input  logic              ResReady,
  output logic [RES_W-1:0]  ResResult,
  output logic [LEN_W-1:0]  ResLen,
  output logic              ResTimeout,
  output logic              Busy
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

  vnlp_state_e       state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d, addr_q, addr_d;
  logic              armed_q, armed_d;
  logic              we_q, we_d, vs_q, vs_d, vr_q, vr_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              rv_q, rv_d, rto_q, rto_d;
  logic [RES_W-1:0]  rres_q, rres_d;
  logic [LEN_W-1:0]  rlen_q, rlen_d;
  logic              wdg_clr, wdg_en, wdg_exp;
  logic [ADDR_W:0]   n_clamp;

  assign n_clamp = (JobWords > DEPTH) ? DEPTH : JobWords;

  vnlp_watchdog #(.TIMEOUT(TIMEOUT)) u_wdg (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear_i   (wdg_clr),
    .enable_i  (wdg_en),
    .expired_o (wdg_exp)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    armed_d = armed_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    vs_d    = 1'b0;
    vr_d    = 1'b0;
    rv_d    = rv_q;
    rres_d  = rres_q;
    rlen_d  = rlen_q;
    rto_d   = rto_q;
    wdg_clr = 1'b0;
    wdg_en  = 1'b0;
    case (state_q)
      IDLE: if (JobValid) begin
        n_d     = n_clamp;
        addr_d  = '0;
        state_d = (n_clamp == '0) ? START : LOAD;
      end
      LOAD: if (InValid) begin
        we_d   = 1'b1;
        wa_d   = addr_q[ADDR_W-1:0];
        wd_d   = InData;
        addr_d = addr_q + 1'b1;
        if (addr_q == n_q - 1'b1) state_d = START;
      end
      START: begin
        vs_d    = 1'b1;
        wdg_clr = 1'b1;
        armed_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        wdg_en = 1'b1;
        // A Done level left over from the previous job is ignored until it drops.
        if (!VDone) armed_d = 1'b1;
        if (armed_q && VDone) begin
          rres_d  = VResult;
          rlen_d  = VLen;
          rto_d   = 1'b0;
          rv_d    = 1'b1;
          state_d = RESP;
        end else if (wdg_exp) begin
          vr_d    = 1'b1;
          state_d = ABORT;
        end
      end
      ABORT: begin
        rres_d  = '0;
        rlen_d  = '0;
        rto_d   = 1'b1;
        rv_d    = 1'b1;
        state_d = RESP;
      end
      RESP: if (ResReady) begin
        rv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      armed_q <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      vs_q    <= 1'b0;
      vr_q    <= 1'b0;
      rv_q    <= 1'b0;
      rres_q  <= '0;
      rlen_q  <= '0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      armed_q <= armed_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      vs_q    <= vs_d;
      vr_q    <= vr_d;
      rv_q    <= rv_d;
      rres_q  <= rres_d;
      rlen_q  <= rlen_d;
      rto_q   <= rto_d;
    end
  end

  assign JobReady     = (state_q == IDLE);
  assign InReady      = (state_q == LOAD);
  assign Busy         = (state_q != IDLE);
  assign MemWriteEn   = we_q;
  assign MemWriteAdd  = wa_q;
  assign MemWriteData = wd_q;
  assign VStart       = vs_q;
  assign VReset       = vr_q;
  assign ResValid     = rv_q;
  assign ResResult    = rres_q;
  assign ResLen       = rlen_q;
  assign ResTimeout   = rto_q;
endmodule

// File: tb/tb_vnlp_job_ctrl.sv
// Directed bench for vnlp_job_ctrl: vector table plus multi-cycle corner sequences.
module tb_vnlp_job_ctrl;
  logic        Clk = 1'b0;
  logic        Reset, JobValid, InValid, VDone, ResReady;
  logic [9:0]  JobWords, InData;
  logic [27:0] VResult;
  logic [7:0]  VLen;
  logic        JobReady, InReady, MemWriteEn, VStart, VReset, ResValid, ResTimeout, Busy;
  logic [8:0]  MemWriteAdd;
  logic [9:0]  MemWriteData;
  logic [27:0] ResResult;
  logic [7:0]  ResLen;

  int nvec = 0;
  int nerr = 0;

  always #5 Clk = ~Clk;

  vnlp_job_ctrl #(.TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .JobValid(JobValid), .JobReady(JobReady), .JobWords(JobWords),
    .InValid(InValid), .InReady(InReady), .InData(InData),
    .MemWriteEn(MemWriteEn), .MemWriteAdd(MemWriteAdd), .MemWriteData(MemWriteData),
    .VStart(VStart), .VReset(VReset), .VDone(VDone), .VResult(VResult), .VLen(VLen),
    .ResValid(ResValid), .ResReady(ResReady), .ResResult(ResResult), .ResLen(ResLen),
    .ResTimeout(ResTimeout), .Busy(Busy)
  );

  typedef struct {
    int jv, jw, iv, id, vd, vres, vlen, rr;
    int jr, ir, we, wa, wd, vs, rv, rres, rlen, busy;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];

  task automatic chk(input string nm, input int act, input int want);
    nvec++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Called at a negedge in START; runs a normal Done handshake and drains the response.
  task automatic run_job(input int r, input int l, input string nm);
    VResult = 28'(r); VLen = 8'(l); VDone = 1'b0;
    repeat (3) @(negedge Clk);
    VDone = 1'b1;
    for (int c = 0; c < 20 && !ResValid; c++) @(negedge Clk);
    chk({nm, "_rv"},   int'(ResValid), 1);
    chk({nm, "_res"},  int'(ResResult), r);
    chk({nm, "_len"},  int'(ResLen), l);
    chk({nm, "_to"},   int'(ResTimeout), 0);
    VDone = 1'b0; ResReady = 1'b1;
    @(negedge Clk);
    ResReady = 1'b0;
    chk({nm, "_rvclr"}, int'(ResValid), 0);
    chk({nm, "_jr"},    int'(JobReady), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] q [$];
    logic [9:0] wexp;
    int nw;

    //            jv jw iv id     vd vres       vlen rr  jr ir we wa wd     vs rv rres       rlen busy
    tv[0]  = '{1, 3, 0, 0,     0, 'h123,     3,   0,  1, 0, 0, 0, 0,     0, 0, 0,         0,   0};
    tv[1]  = '{0, 3, 1, 'h001, 0, 'h123,     3,   0,  0, 1, 0, 0, 0,     0, 0, 0,         0,   1};
    tv[2]  = '{0, 3, 1, 'h002, 0, 'h123,     3,   0,  0, 1, 1, 0, 'h001, 0, 0, 0,         0,   1};
    tv[3]  = '{0, 3, 1, 'h3FF, 0, 'h123,     3,   0,  0, 1, 1, 1, 'h002, 0, 0, 0,         0,   1};
    tv[4]  = '{0, 3, 0, 0,     0, 'h123,     3,   0,  0, 0, 1, 2, 'h3FF, 0, 0, 0,         0,   1};
    tv[5]  = '{0, 3, 0, 0,     0, 'h123,     3,   0,  0, 0, 0, 0, 0,     1, 0, 0,         0,   1};
    tv[6]  = '{0, 3, 0, 0,     1, 'h123,     3,   0,  0, 0, 0, 0, 0,     0, 0, 0,         0,   1};
    tv[7]  = '{0, 3, 0, 0,     0, 'h123,     3,   1,  0, 0, 0, 0, 0,     0, 1, 'h123,     3,   1};
    tv[8]  = '{0, 3, 0, 0,     0, 'h123,     3,   0,  1, 0, 0, 0, 0,     0, 0, 0,         0,   0};
    tv[9]  = '{1, 0, 0, 0,     0, 'hABCDEF1, 0,   0,  1, 0, 0, 0, 0,     0, 0, 0,         0,   0};
    tv[10] = '{0, 0, 0, 0,     0, 'hABCDEF1, 0,   0,  0, 0, 0, 0, 0,     0, 0, 0,         0,   1};
    tv[11] = '{0, 0, 0, 0,     0, 'hABCDEF1, 0,   0,  0, 0, 0, 0, 0,     1, 0, 0,         0,   1};
    tv[12] = '{0, 0, 0, 0,     1, 'hABCDEF1, 0,   0,  0, 0, 0, 0, 0,     0, 0, 0,         0,   1};
    tv[13] = '{0, 0, 0, 0,     0, 'hABCDEF1, 0,   1,  0, 0, 0, 0, 0,     0, 1, 'hABCDEF1, 0,   1};
    tv[14] = '{0, 0, 0, 0,     0, 'hABCDEF1, 0,   0,  1, 0, 0, 0, 0,     0, 0, 0,         0,   0};

    Reset = 1'b1; JobValid = 1'b0; JobWords = '0; InValid = 1'b0; InData = '0;
    VDone = 1'b0; VResult = '0; VLen = '0; ResReady = 1'b0;
    #12;
    chk("rst_we",   int'(MemWriteEn), 0);
    chk("rst_wa",   int'(MemWriteAdd), 0);
    chk("rst_vs",   int'(VStart), 0);
    chk("rst_vr",   int'(VReset), 0);
    chk("rst_rv",   int'(ResValid), 0);
    chk("rst_res",  int'(ResResult), 0);
    chk("rst_to",   int'(ResTimeout), 0);
    chk("rst_busy", int'(Busy), 0);
    @(negedge Clk);
    Reset = 1'b0;

    // 3-word load and zero-word job, cycle by cycle
    for (int i = 0; i < NV; i++) begin
      JobValid = tv[i].jv[0]; JobWords = 10'(tv[i].jw);
      InValid  = tv[i].iv[0]; InData   = 10'(tv[i].id);
      VDone    = tv[i].vd[0]; VResult  = 28'(tv[i].vres); VLen = 8'(tv[i].vlen);
      ResReady = tv[i].rr[0];
      chk($sformatf("v%0d_jr", i),   int'(JobReady), tv[i].jr);
      chk($sformatf("v%0d_ir", i),   int'(InReady), tv[i].ir);
      chk($sformatf("v%0d_we", i),   int'(MemWriteEn), tv[i].we);
      chk($sformatf("v%0d_vs", i),   int'(VStart), tv[i].vs);
      chk($sformatf("v%0d_vr", i),   int'(VReset), 0);
      chk($sformatf("v%0d_rv", i),   int'(ResValid), tv[i].rv);
      chk($sformatf("v%0d_busy", i), int'(Busy), tv[i].busy);
      if (tv[i].we != 0) begin
        chk($sformatf("v%0d_wa", i), int'(MemWriteAdd), tv[i].wa);
        chk($sformatf("v%0d_wd", i), int'(MemWriteData), tv[i].wd);
      end
      if (tv[i].rv != 0) begin
        chk($sformatf("v%0d_res", i), int'(ResResult), tv[i].rres);
        chk($sformatf("v%0d_len", i), int'(ResLen), tv[i].rlen);
        chk($sformatf("v%0d_to", i),  int'(ResTimeout), 0);
      end
      @(negedge Clk);
    end
    JobValid = 1'b0; ResReady = 1'b0; VDone = 1'b0;

    // JobWords=600 clamps to 512, InValid toggling
    JobValid = 1'b1; JobWords = 10'd600;
    @(negedge Clk);
    JobValid = 1'b0;
    nw = 0;
    for (int c = 0; c < 2000 && nw < 512; c++) begin
      InValid = c[0]; InData = 10'(c * 7);
      if (InValid && InReady) q.push_back(InData);
      @(negedge Clk);
      if (MemWriteEn) begin
        wexp = (q.size() > 0) ? q.pop_front() : 10'h0;
        chk("t3_addr", int'(MemWriteAdd), nw);
        chk("t3_data", int'(MemWriteData), int'(wexp));
        nw++;
      end
    end
    InValid = 1'b0;
    chk("t3_nwrites", nw, 512);
    chk("t3_inready_after", int'(InReady), 0);
    chk("t3_queue_left", q.size(), 0);
    run_job('h0000456, 'h12, "t3");

    // Stale Done held across VStart; response held while ResReady low
    JobValid = 1'b1; JobWords = 10'd0; VDone = 1'b1; VResult = 28'hBAD0BAD; VLen = 8'hEE;
    @(negedge Clk);
    JobValid = 1'b0;
    @(negedge Clk);
    chk("t4_vs", int'(VStart), 1);
    chk("t4_rv_stale1", int'(ResValid), 0);
    @(negedge Clk);
    chk("t4_rv_stale2", int'(ResValid), 0);
    VDone = 1'b0;
    @(negedge Clk);
    chk("t4_rv_low", int'(ResValid), 0);
    @(negedge Clk);
    chk("t4_rv_low2", int'(ResValid), 0);
    VDone = 1'b1; VResult = 28'h0C0FFEE; VLen = 8'h55;
    @(negedge Clk);
    VDone = 1'b0; VResult = 28'h1111111; VLen = 8'h22;
    for (int c = 0; c < 5; c++) begin
      chk("t4_rv_hold",  int'(ResValid), 1);
      chk("t4_res_hold", int'(ResResult), 'h0C0FFEE);
      chk("t4_len_hold", int'(ResLen), 'h55);
      chk("t4_jr_hold",  int'(JobReady), 0);
      @(negedge Clk);
    end
    ResReady = 1'b1;
    @(negedge Clk);
    ResReady = 1'b0;
    chk("t4_rv_clr", int'(ResValid), 0);

    // Watchdog abort after 16 RUN cycles without Done
    JobValid = 1'b1; JobWords = 10'd0; VDone = 1'b0; VResult = 28'h7777777; VLen = 8'h77;
    @(negedge Clk);
    JobValid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge Clk);
      chk($sformatf("t5_vr_run%0d", c), int'(VReset), 0);
    end
    @(negedge Clk);
    chk("t5_vr_abort", int'(VReset), 1);
    chk("t5_rv_abort", int'(ResValid), 0);
    @(negedge Clk);
    chk("t5_vr_once", int'(VReset), 0);
    chk("t5_rv",  int'(ResValid), 1);
    chk("t5_res", int'(ResResult), 0);
    chk("t5_len", int'(ResLen), 0);
    chk("t5_to",  int'(ResTimeout), 1);
    chk("t5_jr",  int'(JobReady), 0);
    ResReady = 1'b1;
    @(negedge Clk);
    ResReady = 1'b0;
    chk("t5_rv_clr", int'(ResValid), 0);
    JobValid = 1'b1; JobWords = 10'd0;
    @(negedge Clk);
    JobValid = 1'b0;
    run_job('h1234567, 9, "t5_next");

    // Reset in the middle of a 5-word load
    JobValid = 1'b1; JobWords = 10'd5;
    @(negedge Clk);
    JobValid = 1'b0; InValid = 1'b1; InData = 10'h0AA;
    @(negedge Clk);
    InData = 10'h0BB;
    chk("t6_we0", int'(MemWriteEn), 1);
    @(negedge Clk);
    InValid = 1'b0;
    chk("t6_wa1", int'(MemWriteAdd), 1);
    #2 Reset = 1'b1;
    #1;
    chk("t6_we_async", int'(MemWriteEn), 0);
    chk("t6_wa_async", int'(MemWriteAdd), 0);
    chk("t6_wd_async", int'(MemWriteData), 0);
    chk("t6_busy",     int'(Busy), 0);
    chk("t6_rv",       int'(ResValid), 0);
    @(negedge Clk);
    Reset = 1'b0;
    chk("t6_jr", int'(JobReady), 1);
    JobValid = 1'b1; JobWords = 10'd1;
    @(negedge Clk);
    JobValid = 1'b0; InValid = 1'b1; InData = 10'h155;
    @(negedge Clk);
    InValid = 1'b0;
    chk("t6_new_we", int'(MemWriteEn), 1);
    chk("t6_new_wa", int'(MemWriteAdd), 0);
    chk("t6_new_wd", int'(MemWriteData), 'h155);
    chk("t6_new_ir", int'(InReady), 0);
    run_job('h00000AB, 1, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vnlp_job_ctrl.md
Name: vnlp_job_ctrl

Overview:
- Host-facing job sequencer for the VNLP engine.
- Accepts a job descriptor, then streams the job's operand words into Memory through its otherwise-unused write port.
- Then pulses VNLP Start, waits for Done (with a watchdog), and returns Result/Len to the host over a valid/ready handshake.
- Sits between the host interface and the VNLP top plus Memory write port.

Parameters:
- ADDR_W, 9, Memory address width (512 words)
- DATA_W, 10, Memory word width
- RES_W, 28, VNLP Result width
- LEN_W, 8, VNLP Len width
- TIMEOUT, 4095, max RUN cycles before abort (1..65535)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- JobValid  in  1  host job descriptor valid
- JobReady  out  1  controller can accept a job
- JobWords  in  ADDR_W+1  number of words to load (0..512; larger values clamp to 512)
- InValid  in  1  operand word valid
- InReady  out  1  operand word accepted
- InData  in  DATA_W  operand word
- MemWriteEn  out  1  Memory write enable
- MemWriteAdd  out  ADDR_W  Memory write address
- MemWriteData  out  DATA_W  Memory write data
- VStart  out  1  VNLP Start pulse
- VReset  out  1  VNLP reset pulse (abort)
- VDone  in  1  VNLP Done level
- VResult  in  RES_W  VNLP Result
- VLen  in  LEN_W  VNLP Len
- ResValid  out  1  response valid
- ResReady  in  1  host accepts response
- ResResult  out  RES_W  captured result
- ResLen  out  LEN_W  captured length
- ResTimeout  out  1  response produced by watchdog abort
- Busy  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE; every registered output 0 (MemWriteEn, MemWriteAdd, MemWriteData, VStart, VReset, ResValid, ResResult, ResLen, ResTimeout). Word counter, address and watchdog cleared.
- Reset mid-operation: MemWriteEn and VStart drop immediately; any partial load is abandoned; no response is produced.
- States: IDLE, LOAD, START, RUN, ABORT, RESP.
- IDLE:
  - JobReady=1. Accept on JobValid&JobReady.
  - Latch n = min(JobWords, 512) and zero the address.
  - n==0 -> START; else -> LOAD.
- LOAD:
  - InReady=1 (JobReady=0). Each beat with InValid&InReady is written one cycle later: MemWriteEn=1, MemWriteAdd=addr, MemWriteData=InData (all registered); addr increments.
  - When the n-th beat is accepted -> START. That final write occurs in the first START cycle. No write ever targets addr >= n; the address does not wrap.
  - InValid gaps stall the load indefinitely (no timeout in LOAD).
- START:
  - VStart=1 for exactly one cycle (registered, asserted the cycle after the last write commits), then -> RUN.
  - Watchdog cleared; armed flag cleared.
- RUN:
  - armed sets on the first cycle VDone==0. This rejects stale Done held from a previous job.
  - armed & VDone: capture ResResult=VResult, ResLen=VLen, ResTimeout=0 -> RESP.
  - Watchdog increments each RUN cycle. Reaching TIMEOUT with no accepted Done -> ABORT.
  - If Done and timeout coincide, Done wins.
- ABORT: VReset=1 for one cycle; ResResult=0, ResLen=0, ResTimeout=1 -> RESP.
- RESP:
  - ResValid=1; ResResult, ResLen and ResTimeout held stable until ResReady.
  - On ResValid&ResReady: ResValid clears next cycle -> IDLE.
  - JobReady=0 throughout RESP (no job overlap).
- Busy=1 in every state except IDLE.
- Latency (n words, no stalls): JobValid accept -> first write = 2 cycles; last beat accept -> VStart = 2 cycles; accepted Done -> ResValid = 1 cycle.

Decomposition:
- Shared package vnlp_pkg:
  - state enum (IDLE, LOAD, START, RUN, ABORT, RESP)
  - VNLP_ADDR_W=9, VNLP_DATA_W=10, VNLP_RES_W=28, VNLP_LEN_W=8, VNLP_MEM_DEPTH=512
- One natural sub-module: vnlp_watchdog.
  - Inputs: clear, enable. Output: expired.
  - Width $clog2(TIMEOUT+1).
  - Async-reset by Reset.

Test Plan:
- JobWords=3, data 10'h001, 10'h002, 10'h3FF back-to-back -> writes at addr 0, 1, 2 on consecutive cycles; single-cycle VStart 1 cycle after the addr-2 write; VDone with VResult=28'h0000123, VLen=8'd3 -> ResValid with those values, ResTimeout=0.
- JobWords=0 -> no MemWriteEn at all; VStart 2 cycles after job accept; normal response.
- JobWords=600 with InValid toggling every other cycle -> exactly 512 writes, addr 0..511, no wrap; InReady=0 after the 512th beat.
- VDone held 1 from before VStart, then 0 for 2 cycles, then 1 -> capture only on the second rising level; ResReady held low 5 cycles -> ResValid/ResResult/ResLen stable, JobReady=0.
- TIMEOUT=16, VDone never asserts -> after 16 RUN cycles: one-cycle VReset, ResValid with ResResult=0, ResLen=0, ResTimeout=1; next job then proceeds normally.
- Reset asserted mid-LOAD after 2 of 5 beats -> MemWriteEn=0 asynchronously, all outputs 0, JobReady=1 after release; new JobWords=1 writes addr 0.
